// File: rtl/wb_grf.sv
// Writeback stage and 32x32 general register file with same-cycle write bypass,
// registered commit log and commit counter for trace.
module wb_grf #(
  parameter bit RESET_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_WB,
  input  logic [31:0] ReadData_WB,
  input  logic [31:0] PC8_WB,
  input  logic [31:0] PC_WB,
  input  logic [1:0]  WDCtrl_WB,
  input  logic        GRFWE_WB,
  input  logic [4:0]  WA_WB,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WD_WB,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_data,
  output logic [4:0]  log_addr,
  output logic [31:0] commit_count,
  output logic        wdctrl_err
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        log_valid_q, log_valid_d;
  logic [31:0] log_pc_q, log_pc_d;
  logic [31:0] log_data_q, log_data_d;
  logic [4:0]  log_addr_q, log_addr_d;
  logic [31:0] commit_count_q, commit_count_d;
  logic        wdctrl_err_q, wdctrl_err_d;
  logic        commit;
  logic        illegal_sel;

  always_comb begin
    WD_WB = 32'h0;
    unique case (WDCtrl_WB)
      2'b00:   WD_WB = ALUResult_WB;
      2'b01:   WD_WB = ReadData_WB;
      2'b10:   WD_WB = PC8_WB;
      default: WD_WB = 32'h0;
    endcase
  end

  assign illegal_sel = GRFWE_WB && (WDCtrl_WB == 2'b11);
  assign commit      = !reset && GRFWE_WB && (WA_WB != 5'd0) && (WDCtrl_WB != 2'b11);

  // Register 0 is forced to read zero so it stays zero even without a clearing reset.
  always_comb begin
    RD1 = regs_q[RA1];
    if (RA1 == 5'd0)                 RD1 = 32'h0;
    else if (commit && WA_WB == RA1) RD1 = WD_WB;
    RD2 = regs_q[RA2];
    if (RA2 == 5'd0)                 RD2 = 32'h0;
    else if (commit && WA_WB == RA2) RD2 = WD_WB;
  end

  always_comb begin
    regs_d         = regs_q;
    log_valid_d    = commit;
    log_pc_d       = log_pc_q;
    log_data_d     = log_data_q;
    log_addr_d     = log_addr_q;
    commit_count_d = commit_count_q;
    wdctrl_err_d   = wdctrl_err_q || (illegal_sel && !reset);
    if (reset) begin
      if (RESET_ZERO) begin
        for (int i = 0; i < 32; i++) regs_d[i] = 32'h0;
      end
      log_valid_d    = 1'b0;
      log_pc_d       = 32'h0;
      log_data_d     = 32'h0;
      log_addr_d     = 5'd0;
      commit_count_d = 32'h0;
      wdctrl_err_d   = 1'b0;
    end else if (commit) begin
      regs_d[WA_WB]  = WD_WB;
      log_pc_d       = PC_WB;
      log_data_d     = WD_WB;
      log_addr_d     = WA_WB;
      commit_count_d = commit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    regs_q         <= regs_d;
    log_valid_q    <= log_valid_d;
    log_pc_q       <= log_pc_d;
    log_data_q     <= log_data_d;
    log_addr_q     <= log_addr_d;
    commit_count_q <= commit_count_d;
    wdctrl_err_q   <= wdctrl_err_d;
  end

  assign log_valid    = log_valid_q;
  assign log_pc       = log_pc_q;
  assign log_data     = log_data_q;
  assign log_addr     = log_addr_q;
  assign commit_count = commit_count_q;
  assign wdctrl_err   = wdctrl_err_q;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed plan steps followed by random traffic,
// compared against a behavioural register-file model.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu = '0, mem = '0, pc8 = '0, pc = '0;
  logic [1:0]  ctrl = '0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0, ra1 = '0, ra2 = '0;
  logic [31:0] rd1, rd2, wd;
  logic        log_valid;
  logic [31:0] log_pc, log_data, commit_count;
  logic [4:0]  log_addr;
  logic        wdctrl_err;

  wb_grf #(.RESET_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ALUResult_WB(alu), .ReadData_WB(mem), .PC8_WB(pc8), .PC_WB(pc),
    .WDCtrl_WB(ctrl), .GRFWE_WB(we), .WA_WB(wa), .RA1(ra1), .RA2(ra2),
    .RD1(rd1), .RD2(rd2), .WD_WB(wd),
    .log_valid(log_valid), .log_pc(log_pc), .log_data(log_data), .log_addr(log_addr),
    .commit_count(commit_count), .wdctrl_err(wdctrl_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_lv;
  logic [31:0] m_lpc, m_ldata, m_count;
  logic [4:0]  m_laddr;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [1:0] c,
                      input logic [31:0] v_alu, input logic [31:0] v_mem,
                      input logic [31:0] v_pc8, input logic [31:0] v_pc,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] sel [4];
    logic [31:0] exp_wd;
    logic        cm;
    @(negedge clk);
    reset = r; we = w; wa = a; ctrl = c;
    alu = v_alu; mem = v_mem; pc8 = v_pc8; pc = v_pc; ra1 = r1; ra2 = r2;
    sel[0] = v_alu; sel[1] = v_mem; sel[2] = v_pc8; sel[3] = 32'h0;
    exp_wd = sel[c];
    cm = !r && w && (a != 0) && (c != 2'd3);
    #1;
    chk("wd", wd, exp_wd);
    chk("rd1", rd1, (cm && a == r1) ? exp_wd : m_regs[r1]);
    chk("rd2", rd2, (cm && a == r2) ? exp_wd : m_regs[r2]);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_lv = 1'b0; m_lpc = '0; m_ldata = '0; m_laddr = '0; m_count = '0; m_err = 1'b0;
    end else begin
      m_lv = cm;
      if (cm) begin
        m_regs[a] = exp_wd;
        m_lpc = v_pc; m_ldata = exp_wd; m_laddr = a;
        m_count = m_count + 1;
      end
      if (w && c == 2'd3) m_err = 1'b1;
    end
    #1;
    chk("log_valid", {31'h0, log_valid}, {31'h0, m_lv});
    chk("log_pc", log_pc, m_lpc);
    chk("log_data", log_data, m_ldata);
    chk("log_addr", {27'h0, log_addr}, {27'h0, m_laddr});
    chk("commit_count", commit_count, m_count);
    chk("wdctrl_err", {31'h0, wdctrl_err}, {31'h0, m_err});
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 1'b0, 5'd0, 2'd0, 32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'h0, r1, r2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_lv = 1'b0; m_lpc = '0; m_ldata = '0; m_laddr = '0; m_count = '0; m_err = 1'b0;

    // Reset with a would-be commit present: must be discarded.
    step(1'b1, 1'b1, 5'd3, 2'd0, 32'h11111111, 0, 0, 32'h100, 5'd3, 5'd0);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    // ALU commit to r5 with same-cycle bypass, then array read.
    step(1'b0, 1'b1, 5'd5, 2'd0, 32'h12345678, 32'h0, 32'h0, 32'h00001000, 5'd5, 5'd5);
    chk("plan_bypass_log_addr", {27'h0, log_addr}, 32'd5);
    idle(5'd5, 5'd0);

    // Write to r0 is ignored everywhere.
    step(1'b0, 1'b1, 5'd0, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00001004, 5'd0, 5'd0);
    idle(5'd0, 5'd5);

    // Back-to-back commits to r31: memory data, then link value.
    step(1'b0, 1'b1, 5'd31, 2'd1, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h00001008, 5'd31, 5'd1);
    step(1'b0, 1'b1, 5'd31, 2'd2, 32'h0, 32'h0, 32'h00003008, 32'h0000100C, 5'd31, 5'd31);
    idle(5'd31, 5'd5);
    chk("plan_r31_count", commit_count, 32'd3);

    // Illegal select: no write, sticky error through later legal commits.
    step(1'b0, 1'b1, 5'd7, 2'd3, 32'h77777777, 32'h77777777, 32'h77777777, 32'h00001010, 5'd7, 5'd7);
    idle(5'd7, 5'd7);
    step(1'b0, 1'b1, 5'd8, 2'd0, 32'h88888888, 0, 0, 32'h00001014, 5'd8, 5'd7);
    step(1'b0, 1'b1, 5'd8, 2'd1, 0, 32'h99999999, 0, 32'h00001018, 5'd7, 5'd8);

    // Counter wrap from all-ones.
    force dut.commit_count_d = 32'hFFFFFFFF;
    m_count = 32'hFFFFFFFF;
    idle(5'd1, 5'd2);
    release dut.commit_count_d;
    step(1'b0, 1'b1, 5'd2, 2'd0, 32'h0BADF00D, 0, 0, 32'h0000101C, 5'd2, 5'd2);
    chk("plan_wrap", commit_count, 32'h0);

    // Reset arriving together with a commit to r9.
    step(1'b0, 1'b1, 5'd9, 2'd0, 32'h99990000, 0, 0, 32'h00001020, 5'd9, 5'd0);
    step(1'b1, 1'b1, 5'd9, 2'd0, 32'h99990001, 0, 0, 32'h00001024, 5'd9, 5'd0);
    idle(5'd9, 5'd8);
    chk("plan_reset_err", {31'h0, wdctrl_err}, 32'h0);

    // Random traffic with occasional resets and register-address collisions.
    for (int n = 0; n < 400; n++) begin
      logic [4:0]  a, r1, r2;
      logic [1:0]  c;
      a  = 5'($urandom_range(0, 31));
      c  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r1 = ($urandom_range(0, 1) == 1) ? a : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), a, c,
           $urandom, $urandom, $urandom, $urandom, r1, r2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
# wb_grf

Writeback stage and general register file for the five-stage pipelined CPU. It consumes the MEM/WB pipeline register outputs and selects the writeback data. It commits that data to a 32×32 register file and serves the two decode-stage read ports with same-cycle write bypass. It also produces a registered commit log and a commit counter for testbench tracing.

## Interface
- RESET_ZERO, default 1: reset clears all 32 registers to 0. When 0, only the log and counters are cleared.
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high; clock clk
- ALUResult_WB  in  32  ALU result from MEM/WB
- ReadData_WB  in  32  data-memory read data from MEM/WB
- PC8_WB  in  32  PC+8 (link value) from MEM/WB
- PC_WB  in  32  PC of the instruction in WB
- WDCtrl_WB  in  2  write-data select: 00 ALU, 01 memory, 10 PC8, 11 illegal
- GRFWE_WB  in  1  register write enable
- WA_WB  in  5  destination register
- RA1, RA2  in  5  decode-stage read addresses
- RD1, RD2  out  32  read data, bypassed (combinational)
- WD_WB  out  32  selected writeback data (combinational), also used for forwarding to earlier stages
- log_valid  out  1  one-cycle pulse: a commit occurred on the previous edge
- log_pc, log_data  out  32  PC and data of that commit
- log_addr  out  5  register of that commit
- commit_count  out  32  number of commits since reset, wraps
- wdctrl_err  out  1  sticky: an illegal WDCtrl was seen with GRFWE_WB=1

## Operation
- WD_WB selection:
  - 00 → ALUResult_WB
  - 01 → ReadData_WB
  - 10 → PC8_WB
  - 11 → 32'h0
- A commit occurs on a posedge when all of these hold: reset=0, GRFWE_WB=1, WA_WB≠0, WDCtrl_WB≠11. On a commit, the register at WA_WB is loaded with WD_WB.
- Register 0 is never written and always reads 0, bypass included.
- If GRFWE_WB=1 and WDCtrl_WB=11, no write occurs, wdctrl_err sets and stays set until reset, and no log pulse is produced.
- Read port n: if a commit condition is true this cycle and WA_WB==RAn, RDn=WD_WB. Otherwise RDn=reg[RAn].
- Commit log registers capture PC_WB, WA_WB and WD_WB on every commit edge. log_valid=1 for exactly the following cycle. With no commit, log_valid=0 and the log data registers hold their values.
- commit_count increments by 1 per commit and wraps from 32'hFFFFFFFF to 0.
- Unused WB slots (GRFWE_WB=0) have no effect beyond driving WD_WB.

## Timing
- Write latency: data is visible through the array on the cycle after the commit edge. It is visible through the bypass in the same cycle.
- Reset, at the first posedge with reset=1:
  - registers are cleared when RESET_ZERO=1
  - log_valid=0, log_pc/log_addr/log_data=0
  - commit_count=0, wdctrl_err=0
  - no commit occurs on that edge even if GRFWE_WB=1
- Reset asserted mid-stream: an instruction in WB on the reset edge is discarded. The first commit after deassertion produces log_valid one cycle later.
- Back-to-back commits to the same register: the last one wins. log_valid stays high on consecutive cycles, one pulse per commit.
- RA1==RA2==WA_WB: both ports bypass.

## Test plan
- Reset, then read all 32 addresses → all 0. log_valid=0, commit_count=0, wdctrl_err=0.
- WDCtrl=00, ALUResult=32'h12345678, WA=5, GRFWE=1, RA1=5 in the same cycle:
  - RD1=32'h12345678 via bypass in that cycle.
  - Next cycle RD1=32'h12345678 from the array, log_valid=1, log_addr=5, log_data=32'h12345678, log_pc=PC_WB, commit_count=1.
- WA=0, GRFWE=1, ALUResult=32'hFFFFFFFF, RA1=0 → RD1=0 in that cycle and the next. No log pulse, count unchanged.
- Successive writes to reg 31 with WDCtrl=01 (ReadData=32'hA5A5A5A5), then WDCtrl=10 (PC8=32'h00003008) → reg 31 final value 32'h00003008. Two consecutive log pulses, count +2.
- WDCtrl=11, GRFWE=1, WA=7 → reg 7 unchanged and wdctrl_err=1 from the next cycle. It stays 1 after further legal commits and clears only on reset.
- Preload commit_count to 32'hFFFFFFFF via a force, then one commit → commit_count=0.
- Assert reset in the same cycle as a commit to reg 9 → reg 9=0 (RESET_ZERO=1), log_valid=0 next cycle.
